// File: rtl/traffic_pkg.sv
// traffic_pkg: state codes, lamp-vector indices and lamp decode for the intersection controller
package traffic_pkg;
  typedef enum logic [2:0] {AR_NS, NS_G, NS_Y, AR_EW, EW_G, EW_Y, PED, FLASH} state_t;
  localparam int L_NS_RED = 0;
  localparam int L_NS_YEL = 1;
  localparam int L_NS_GRN = 2;
  localparam int L_EW_RED = 3;
  localparam int L_EW_YEL = 4;
  localparam int L_EW_GRN = 5;
  localparam int L_WALK   = 6;
  localparam int L_N      = 7;
  function automatic logic [L_N-1:0] state_to_lamps(state_t s, logic blink);
    logic [L_N-1:0] l;
    l[L_NS_RED] = !(s inside {NS_G, NS_Y, FLASH});
    l[L_NS_YEL] = s == NS_Y || (s == FLASH && blink);
    l[L_NS_GRN] = s == NS_G;
    l[L_EW_RED] = !(s inside {EW_G, EW_Y, FLASH});
    l[L_EW_YEL] = s == EW_Y || (s == FLASH && blink);
    l[L_EW_GRN] = s == EW_G;
    l[L_WALK]   = s == PED;
    return l;
  endfunction
endpackage

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: phase counter that flags the last cycle of a phase of length limit
module traffic_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  assign done = cnt == limit - CNT_W'(1);
  // count up, restarting on every phase boundary
  always_ff @(posedge clk)
    cnt <= (rst || load) ? '0 : cnt + CNT_W'(1);
  assert property (@(posedge clk) disable iff (rst) cnt <= limit - CNT_W'(1));
endmodule

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: NS/EW intersection sequencer with all-red clearance, pedestrian walk and night flashing mode
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int T_GREEN  = 32,
  parameter int T_YELLOW = 6,
  parameter int T_ALLRED = 2,
  parameter int T_PED    = 16,
  parameter int T_FLASH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_o
);
  localparam int T_MAX = 2 ** CNT_W - 1;
  if (T_GREEN < 1 || T_GREEN > T_MAX || T_YELLOW < 1 || T_YELLOW > T_MAX ||
      T_ALLRED < 1 || T_ALLRED > T_MAX || T_PED < 1 || T_PED > T_MAX ||
      T_FLASH < 1 || T_FLASH > T_MAX) begin : g_range
    $error("traffic_intersection_ctrl: phase durations must lie in 1..2**CNT_W-1");
  end
  state_t state, nxt;
  logic done, blink, blink_nxt, resume_ew, enter_ped;
  logic [CNT_W-1:0] limit;
  logic [L_N-1:0] lamps;
  // every phase, and every FLASH half-period, ends on done, so done doubles as the restart
  traffic_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (done),
    .limit(limit),
    .done (done)
  );
  // duration of the current state
  always_comb
    limit = (state == AR_NS || state == AR_EW) ? CNT_W'(T_ALLRED) :
            (state == NS_G  || state == EW_G)  ? CNT_W'(T_GREEN)  :
            (state == NS_Y  || state == EW_Y)  ? CNT_W'(T_YELLOW) :
            (state == PED)                     ? CNT_W'(T_PED)    : CNT_W'(T_FLASH);
  // next state: all-red ends choose night, then pedestrian, then the ring
  always_comb begin
    nxt = state;
    if (done)
      case (state)
        AR_NS:   nxt = night_mode ? FLASH : ped_pending ? PED : NS_G;
        NS_G:    nxt = NS_Y;
        NS_Y:    nxt = AR_EW;
        AR_EW:   nxt = night_mode ? FLASH : ped_pending ? PED : EW_G;
        EW_G:    nxt = EW_Y;
        EW_Y:    nxt = AR_NS;
        PED:     nxt = resume_ew ? EW_G : NS_G;
        default: nxt = night_mode ? FLASH : AR_NS;
      endcase
  end
  assign enter_ped = nxt == PED && state != PED;
  assign blink_nxt = (nxt == FLASH && state != FLASH) ? 1'b1 :
                     (state == FLASH && done)         ? ~blink : blink;
  // state, request latches and lamps registered together so outputs track state exactly
  always_ff @(posedge clk)
    if (rst) begin
      state       <= AR_NS;
      blink       <= 1'b0;
      ped_pending <= 1'b0;
      resume_ew   <= 1'b0;
      lamps       <= state_to_lamps(AR_NS, 1'b0);
    end else begin
      state       <= nxt;
      blink       <= blink_nxt;
      ped_pending <= enter_ped ? 1'b0 : (state != PED && ped_req) ? 1'b1 : ped_pending;
      resume_ew   <= enter_ped ? state == AR_EW : (state == FLASH && nxt == AR_NS) ? 1'b0 : resume_ew;
      lamps       <= state_to_lamps(nxt, blink_nxt);
    end
  assign ns_red    = lamps[L_NS_RED];
  assign ns_yellow = lamps[L_NS_YEL];
  assign ns_green  = lamps[L_NS_GRN];
  assign ew_red    = lamps[L_EW_RED];
  assign ew_yellow = lamps[L_EW_YEL];
  assign ew_green  = lamps[L_EW_GRN];
  assign walk      = lamps[L_WALK];
  assign state_o   = state;
  assert property (@(posedge clk) disable iff (rst) !(ns_green && ew_green));
  assert property (@(posedge clk) disable iff (rst) state != FLASH |-> !(ns_green && ew_yellow) && !(ns_yellow && ew_green));
  assert property (@(posedge clk) disable iff (rst) walk |-> state == PED);
endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl: vector table, directed corner sequences and randomized run against a rule-level model
module tb_traffic_intersection_ctrl;
  import traffic_pkg::*;
  localparam int T_GREEN = 4, T_YELLOW = 2, T_ALLRED = 1, T_PED = 3, T_FLASH = 2;
  logic clk = 0, rst = 1, ped_req = 0, night_mode = 0;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending;
  logic [2:0] state_o;
  int tests = 0, fails = 0;
  traffic_intersection_ctrl #(.CNT_W(8), .T_GREEN(T_GREEN), .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED),
                              .T_PED(T_PED), .T_FLASH(T_FLASH)) dut (
    .clk(clk), .rst(rst), .ped_req(ped_req), .night_mode(night_mode),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .ped_pending(ped_pending), .state_o(state_o)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  state_t ring [6] = '{AR_NS, NS_G, NS_Y, AR_EW, EW_G, EW_Y};
  state_t m_st = AR_NS;
  int m_age = 0;
  bit m_pp = 0, m_res = 0, m_blink = 0;
  function automatic int dur(state_t s);
    return (s == AR_NS || s == AR_EW) ? T_ALLRED : (s == NS_G || s == EW_G) ? T_GREEN :
           (s == NS_Y || s == EW_Y) ? T_YELLOW : (s == PED) ? T_PED : T_FLASH;
  endfunction
  function automatic state_t ring_next(state_t s);
    for (int i = 0; i < 6; i++) if (ring[i] == s) return ring[(i + 1) % 6];
    return AR_NS;
  endfunction
  task automatic model(bit r, bit pr, bit nm);
    state_t n;
    bit fin;
    if (r) begin
      m_st = AR_NS; m_age = 0; m_pp = 0; m_res = 0; m_blink = 0;
      return;
    end
    fin = (m_age + 1) % dur(m_st) == 0;
    n = m_st;
    if (fin) begin
      if (m_st == FLASH) n = nm ? FLASH : AR_NS;
      else if (m_st == PED) n = m_res ? EW_G : NS_G;
      else if ((m_st == AR_NS || m_st == AR_EW) && nm) n = FLASH;
      else if ((m_st == AR_NS || m_st == AR_EW) && m_pp) n = PED;
      else n = ring_next(m_st);
    end
    if (n == PED && m_st != PED) begin
      m_pp = 0;
      m_res = m_st == AR_EW;
    end else if (m_st != PED && pr) m_pp = 1;
    if (m_st == FLASH && n == AR_NS) m_res = 0;
    if (m_st == FLASH && fin) m_blink = !m_blink;
    if (n == FLASH && m_st != FLASH) m_blink = 1;
    m_age = fin ? 0 : m_age + 1;
    m_st = n;
  endtask
  function automatic logic [6:0] exp_lamps();
    bit fl = m_st == FLASH;
    return {m_st == PED, m_st == EW_G, m_st == EW_Y || (fl && m_blink),
            !(fl || m_st == EW_G || m_st == EW_Y),
            m_st == NS_G, m_st == NS_Y || (fl && m_blink),
            !(fl || m_st == NS_G || m_st == NS_Y)};
  endfunction
  task automatic chk(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask
  task automatic step(bit r, bit pr, bit nm);
    rst = r; ped_req = pr; night_mode = nm;
    model(r, pr, nm);
    @(posedge clk);
    #1;
    chk("model_state", state_o, m_st);
    chk("model_lamps", {walk, ew_green, ew_yellow, ew_red, ns_green, ns_yellow, ns_red}, exp_lamps());
    chk("model_ped_pending", ped_pending, m_pp);
  endtask
  task automatic wait_for(state_t s, bit pr, bit nm, int budget, string name);
    for (int k = 0; k < budget && m_st != s; k++) step(0, pr, nm);
    chk(name, state_o, s);
  endtask
  typedef struct {
    bit r, pr, nm;
    state_t st;
    bit pp, wk;
  } vec_t;
  vec_t tbl [12];
  initial begin
    int first, second;
    logic [2:0] prev;
    bit nm;
    bit yel [4] = '{1, 0, 0, 1};
    tbl[0]  = '{1, 0, 0, AR_NS, 0, 0};
    tbl[1]  = '{0, 0, 0, NS_G,  0, 0};
    tbl[2]  = '{0, 1, 0, NS_G,  1, 0};
    tbl[3]  = '{0, 0, 0, NS_G,  1, 0};
    tbl[4]  = '{0, 0, 0, NS_G,  1, 0};
    tbl[5]  = '{0, 0, 0, NS_Y,  1, 0};
    tbl[6]  = '{0, 0, 0, NS_Y,  1, 0};
    tbl[7]  = '{0, 0, 0, AR_EW, 1, 0};
    tbl[8]  = '{0, 0, 0, PED,   0, 1};
    tbl[9]  = '{0, 0, 0, PED,   0, 1};
    tbl[10] = '{0, 0, 0, PED,   0, 1};
    tbl[11] = '{0, 0, 0, EW_G,  0, 0};
    // ring period after reset with idle inputs
    step(1, 0, 0);
    chk("reset_reds", {ns_red, ew_red, ns_yellow, ns_green, ew_yellow, ew_green, walk}, 7'b1100000);
    first = -1; second = -1; prev = state_o;
    for (int k = 1; k <= 30; k++) begin
      step(0, 0, 0);
      if (k == 1) chk("ns_g_after_reset", state_o, NS_G);
      if (state_o == AR_NS && prev != AR_NS) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      prev = state_o;
    end
    chk("ring_first_wrap", first, 14);
    chk("ring_period", second - first, 14);
    // table: reset, pedestrian pulse in NS_G served after AR_EW, resume to EW_G
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].pr, tbl[i].nm);
      chk($sformatf("tbl%0d_state", i), state_o, tbl[i].st);
      chk($sformatf("tbl%0d_pp", i), ped_pending, tbl[i].pp);
      chk($sformatf("tbl%0d_walk", i), walk, tbl[i].wk);
    end
    // night mode raised in EW_G takes effect only when AR_NS ends
    wait_for(AR_NS, 0, 1, 10, "night_waits_allred");
    step(0, 0, 1);
    chk("flash_entry", state_o, FLASH);
    chk("flash_yel0", ns_yellow, 1);
    foreach (yel[i]) begin
      step(0, 0, 1);
      chk($sformatf("flash_yel%0d", i + 1), ns_yellow && ew_yellow, yel[i]);
    end
    step(0, 0, 0);
    chk("flash_hold_to_toggle", state_o, FLASH);
    step(0, 0, 0);
    chk("flash_exit", state_o, AR_NS);
    step(0, 0, 0);
    chk("flash_exit_ring", state_o, NS_G);
    // ped_req held through PED is not re-latched
    step(0, 1, 0);
    wait_for(PED, 0, 0, 20, "ped_reached");
    for (int k = 0; k < 10 && m_st == PED; k++) step(0, 1, 0);
    chk("ped_hold_resume", state_o, EW_G);
    chk("ped_hold_not_latched", ped_pending, 0);
    // reset mid NS_Y with a pending request
    wait_for(NS_G, 0, 0, 20, "reach_ns_g");
    step(0, 1, 0);
    wait_for(NS_Y, 0, 0, 10, "reach_ns_y");
    chk("pp_before_reset", ped_pending, 1);
    step(1, 0, 0);
    chk("mid_reset_state", state_o, AR_NS);
    chk("mid_reset_lamps", {ns_red, ew_red, walk, ped_pending}, 4'b1100);
    // night and pedestrian together at AR_EW end: FLASH first, pedestrian kept for later
    wait_for(AR_EW, 0, 0, 20, "reach_ar_ew");
    step(0, 1, 1);
    chk("both_flash", state_o, FLASH);
    chk("both_pp_kept", ped_pending, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 1);
    wait_for(AR_NS, 0, 0, 10, "both_exit");
    step(0, 0, 0);
    chk("both_ped", state_o, PED);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("both_resume_ns", state_o, NS_G);
    // randomized run against the model
    nm = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) nm = !nm;
      step($urandom_range(0, 399) == 0, $urandom_range(0, 15) == 0, nm);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
